// File: rtl/dpram_port0_arbiter.sv
// dpram_port0_arbiter: arbitrates two requesters onto RAM port 0 with
// round-robin fairness, lockable ownership bursts and tagged read returns.
module dpram_port0_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic                  lock_a,
    input  logic                  lock_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_wr_en,
    output logic                  ram_port_en_0,
    output logic [ADDR_WIDTH-1:0] ram_addr_0,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out_0
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    state_t                state_q, state_d;
    logic                  last_b_q, last_b_d;   // 1: B was granted most recently
    logic [CW-1:0]         burst_q, burst_d;     // grants given to current owner
    logic                  gnt_a_c, gnt_b_c;
    logic                  idle_gnt_a, idle_gnt_b;
    logic                  gnt_any;
    logic                  we_sel;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    logic                  port_en_q, wr_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rd_pend_a_q, rd_pend_b_q;
    logic                  rvalid_a_q, rvalid_b_q;

    // Round-robin decision used whenever nobody holds ownership
    assign idle_gnt_a = req_a & (~req_b | last_b_q);
    assign idle_gnt_b = req_b & (~req_a | ~last_b_q);

    // Grant selection and next ownership / pointer / burst count
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        burst_d  = burst_q;
        gnt_a_c  = 1'b0;
        gnt_b_c  = 1'b0;

        case (state_q)
            OWN_A: begin
                if (req_a && lock_a) begin
                    if (req_b && (burst_q >= BURST_LIMIT)) gnt_b_c = 1'b1;
                    else                                   gnt_a_c = 1'b1;
                end else begin
                    gnt_a_c = idle_gnt_a;
                    gnt_b_c = idle_gnt_b;
                end
            end
            OWN_B: begin
                if (req_b && lock_b) begin
                    if (req_a && (burst_q >= BURST_LIMIT)) gnt_a_c = 1'b1;
                    else                                   gnt_b_c = 1'b1;
                end else begin
                    gnt_a_c = idle_gnt_a;
                    gnt_b_c = idle_gnt_b;
                end
            end
            default: begin
                gnt_a_c = idle_gnt_a;
                gnt_b_c = idle_gnt_b;
            end
        endcase

        // Burst count includes the grant that takes ownership, so an owner
        // gets MAX_BURST beats in total before yielding; saturates when alone.
        if (gnt_a_c) begin
            last_b_d = 1'b0;
            if (lock_a) begin
                state_d = OWN_A;
                if (state_q == OWN_A)
                    burst_d = (burst_q >= BURST_LIMIT) ? burst_q : burst_q + CW'(1);
                else
                    burst_d = CW'(1);
            end else begin
                state_d = IDLE;
                burst_d = '0;
            end
        end else if (gnt_b_c) begin
            last_b_d = 1'b1;
            if (lock_b) begin
                state_d = OWN_B;
                if (state_q == OWN_B)
                    burst_d = (burst_q >= BURST_LIMIT) ? burst_q : burst_q + CW'(1);
                else
                    burst_d = CW'(1);
            end else begin
                state_d = IDLE;
                burst_d = '0;
            end
        end else begin
            state_d = IDLE;
            burst_d = '0;
        end
    end

    assign gnt_any   = gnt_a_c | gnt_b_c;
    assign we_sel    = gnt_b_c ? we_b    : we_a;
    assign addr_sel  = gnt_b_c ? addr_b  : addr_a;
    assign wdata_sel = gnt_b_c ? wdata_b : wdata_a;

    // Ownership state, round-robin pointer and burst counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            burst_q  <= burst_d;
        end
    end

    // Register the accepted command onto the RAM port; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            port_en_q <= gnt_any;
            wr_en_q   <= gnt_any & we_sel;
            if (gnt_any) begin
                addr_q <= addr_sel;
                data_q <= wdata_sel;
            end
        end
    end

    // Two-stage read tag pipeline aligned with the RAM's registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_a_q <= 1'b0;
            rd_pend_b_q <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
        end else begin
            rd_pend_a_q <= gnt_a_c & ~we_a;
            rd_pend_b_q <= gnt_b_c & ~we_b;
            rvalid_a_q  <= rd_pend_a_q;
            rvalid_b_q  <= rd_pend_b_q;
        end
    end

    assign gnt_a         = gnt_a_c & rst_n;
    assign gnt_b         = gnt_b_c & rst_n;
    assign rvalid_a      = rvalid_a_q;
    assign rvalid_b      = rvalid_b_q;
    assign rdata         = ram_data_out_0;
    assign ram_wr_en     = wr_en_q;
    assign ram_port_en_0 = port_en_q;
    assign ram_addr_0    = addr_q;
    assign ram_data_in   = data_q;

endmodule

// File: tb/tb_dpram_port0_arbiter.sv
// tb_dpram_port0_arbiter: directed stimulus with scoreboard queues for grants,
// RAM commands and read returns, checked by an independent monitor.
module tb_dpram_port0_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, req_b, we_a, we_b, lock_a, lock_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata;
    logic          ram_wr_en, ram_port_en_0;
    logic [AW-1:0] ram_addr_0;
    logic [DW-1:0] ram_data_in, ram_data_out_0;

    dpram_port0_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_a         (req_a),
        .req_b         (req_b),
        .we_a          (we_a),
        .we_b          (we_b),
        .lock_a        (lock_a),
        .lock_b        (lock_b),
        .addr_a        (addr_a),
        .addr_b        (addr_b),
        .wdata_a       (wdata_a),
        .wdata_b       (wdata_b),
        .gnt_a         (gnt_a),
        .gnt_b         (gnt_b),
        .rvalid_a      (rvalid_a),
        .rvalid_b      (rvalid_b),
        .rdata         (rdata),
        .ram_wr_en     (ram_wr_en),
        .ram_port_en_0 (ram_port_en_0),
        .ram_addr_0    (ram_addr_0),
        .ram_data_in   (ram_data_in),
        .ram_data_out_0(ram_data_out_0)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read output
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        if (ram_port_en_0) begin
            if (ram_wr_en) mem[ram_addr_0] <= ram_data_in;
            else           ram_data_out_0  <= mem[ram_addr_0];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int who; int cyc; } gexp_t;
    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cexp_t;
    typedef struct { int who; int cyc; logic [DW-1:0] data; } rexp_t;

    gexp_t gq[$];
    cexp_t cq[$];
    rexp_t rq[$];
    logic [DW-1:0] shadow [1<<AW];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus; eg = expected grant (0 none, 1 A, 2 B)
    task automatic step(input bit ra, input bit la, input bit wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input bit rb, input bit lb, input bit wb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db, input int eg);
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        req_a = ra; lock_a = la; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; lock_b = lb; we_b = wb; addr_b = ab; wdata_b = db;
        if (eg != 0) begin
            w = (eg == 1) ? wa : wb;
            a = (eg == 1) ? aa : ab;
            d = (eg == 1) ? da : db;
            gq.push_back('{eg, cyc});
            cq.push_back('{cyc + 1, w, a, d});
            if (w) shadow[a] = d;
            else   rq.push_back('{eg, cyc + 2, shadow[a]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, command or read
    always @(negedge clk) begin
        gexp_t g;
        cexp_t c;
        rexp_t r;
        if (!rst_n) begin
            chk("reset_ctrl_outputs", {gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wr_en, ram_port_en_0}, '0);
        end else begin
            chk("gnt_onehot", gnt_a & gnt_b, 0);
            if (gnt_a || gnt_b) begin
                if (gq.size() == 0) chk("gnt_unexpected", {gnt_a, gnt_b}, 0);
                else begin
                    g = gq.pop_front();
                    chk("gnt_who", gnt_b ? 2 : 1, g.who);
                    chk("gnt_cycle", cyc, g.cyc);
                end
            end
            if (ram_port_en_0) begin
                if (cq.size() == 0) chk("cmd_unexpected", ram_port_en_0, 0);
                else begin
                    c = cq.pop_front();
                    chk("cmd_cycle", cyc, c.cyc);
                    chk("cmd_we", ram_wr_en, c.we);
                    chk("cmd_addr", ram_addr_0, c.addr);
                    if (c.we) chk("cmd_wdata", ram_data_in, c.data);
                end
            end
            if (rvalid_a || rvalid_b) begin
                if (rq.size() == 0) chk("rvalid_unexpected", {rvalid_a, rvalid_b}, 0);
                else begin
                    r = rq.pop_front();
                    chk("rvalid_who", {rvalid_a, rvalid_b}, (r.who == 1) ? 2 : 1);
                    chk("rvalid_cycle", cyc, r.cyc);
                    chk("rdata", rdata, r.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ia, ib, eg, rst_cyc;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        rst_n = 1'b0;
        req_a = 1; req_b = 1; lock_a = 0; lock_b = 0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_addr", ram_addr_0, 0);
        chk("rst_wdata", ram_data_in, 0);
        req_a = 0; req_b = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention without lock: A first, then strict alternation (writes)
        for (int k = 0; k < 8; k++) begin
            ia = (k + 1) / 2; ib = k / 2;
            step(ia < 4, 0, 1, AW'(ia), DW'(8'hA0 + ia), 1, 0, 1, AW'(8 + ib), DW'(8'hB0 + ib),
                 (k % 2 == 0) ? 1 : 2);
        end
        // Alternating reads back-to-back, tags in order
        for (int k = 0; k < 8; k++) begin
            ia = (k + 1) / 2; ib = k / 2;
            step(ia < 4, 0, 0, AW'(8 + ia), '0, 1, 0, 0, AW'(ib), '0, (k % 2 == 0) ? 1 : 2);
        end
        idle(2);

        // A alone: fill 0..15 with 1..16, then read back
        for (int i = 0; i < 16; i++) step(1, 0, 1, AW'(i), DW'(i + 1), 0, 0, 0, '0, '0, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 0, AW'(i), '0, 0, 0, 0, '0, '0, 1);
        idle(3);

        // Locked burst: pointer moved to B first so A wins entry; A x4, B, A x4, B
        step(0, 0, 0, '0, '0, 1, 0, 0, 4'd5, '0, 2);
        ia = 0; ib = 0;
        for (int k = 0; k < 10; k++) begin
            eg = (k % 5 == 4) ? 2 : 1;
            step(1, 1, 0, AW'(ia), '0, 1, 0, 0, AW'(8 + ib), '0, eg);
            if (eg == 1) ia++; else ib++;
        end
        idle(2);

        // Locked A alone twice, then B joins: burst counts from ownership start
        step(1, 1, 0, 4'd1, '0, 0, 0, 0, '0, '0, 1);
        step(1, 1, 0, 4'd2, '0, 0, 0, 0, '0, '0, 1);
        step(1, 1, 0, 4'd3, '0, 1, 0, 0, 4'd6, '0, 1);
        step(1, 1, 0, 4'd4, '0, 1, 0, 0, 4'd6, '0, 1);
        step(1, 1, 0, 4'd5, '0, 1, 0, 0, 4'd6, '0, 2);
        idle(2);

        // Write by A then immediate read of same address by B
        step(1, 0, 1, 4'd3, 8'h5A, 0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1, 0, 0, 4'd3, '0, 2);
        idle(3);

        // lock_a dropped mid-burst with B waiting: B granted that cycle
        step(1, 1, 0, 4'd0, '0, 1, 0, 0, 4'd3, '0, 1);
        step(1, 1, 0, 4'd1, '0, 1, 0, 0, 4'd3, '0, 1);
        step(1, 0, 0, 4'd2, '0, 1, 0, 0, 4'd3, '0, 2);
        step(1, 0, 0, 4'd2, '0, 0, 0, 0, '0, '0, 1);
        idle(2);

        // Reset with two reads in flight (B then A, so pointer would favour B)
        step(0, 0, 0, '0, '0, 1, 0, 0, 4'd7, '0, 2);
        step(1, 0, 0, 4'd4, '0, 0, 0, 0, '0, '0, 1);
        rst_cyc = cyc;
        rst_n = 1'b0;
        req_a = 1; req_b = 1;
        #1;
        chk("midrst_gnt_a", gnt_a, 0);
        chk("midrst_gnt_b", gnt_b, 0);
        chk("midrst_rvalid", {rvalid_a, rvalid_b}, 0);
        chk("midrst_port_en", ram_port_en_0, 0);
        chk("midrst_wr_en", ram_wr_en, 0);
        chk("midrst_addr", ram_addr_0, 0);
        chk("midrst_wdata", ram_data_in, 0);
        while (cq.size() > 0 && cq[$].cyc >= rst_cyc) void'(cq.pop_back());
        while (rq.size() > 0 && rq[$].cyc >= rst_cyc) void'(rq.pop_back());
        repeat (3) @(posedge clk);
        #1;
        req_a = 0; req_b = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 0, 4'd0, '0, 1, 0, 0, 4'd1, '0, 1);
        step(0, 0, 0, '0, '0, 1, 0, 0, 4'd1, '0, 2);
        idle(4);

        chk("grant_queue_drained", gq.size(), 0);
        chk("cmd_queue_drained", cq.size(), 0);
        chk("read_queue_drained", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
